// File: rtl/stage_decode_read_pkg.sv
// Opcode encodings, architectural register numbers and decode-control types
// shared by decode/register-read and writeback.
package stage_decode_read_pkg;

  localparam logic [4:0] OP_R    = 5'b00000;
  localparam logic [4:0] OP_J    = 5'b00001;
  localparam logic [4:0] OP_BNE  = 5'b00010;
  localparam logic [4:0] OP_JAL  = 5'b00011;
  localparam logic [4:0] OP_JR   = 5'b00100;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_BLT  = 5'b00110;
  localparam logic [4:0] OP_SW   = 5'b00111;
  localparam logic [4:0] OP_LW   = 5'b01000;
  localparam logic [4:0] OP_SETX = 5'b10101;
  localparam logic [4:0] OP_BEX  = 5'b10110;

  localparam logic [4:0] REG_ZERO   = 5'd0;
  localparam logic [4:0] REG_STATUS = 5'd30;
  localparam logic [4:0] REG_RA     = 5'd31;

  typedef enum logic [1:0] {SEL_RS, SEL_RT, SEL_RD, SEL_STATUS} reg_sel_e;

  typedef struct packed {
    reg_sel_e sel_a;
    reg_sel_e sel_b;
    logic     uses_a;
    logic     uses_b;
    logic     is_lw;
  } dec_ctrl_t;

  function automatic logic [4:0] pick_reg(input reg_sel_e sel, input logic [31:0] insn);
    case (sel)
      SEL_RD:     return insn[26:22];
      SEL_RT:     return insn[16:12];
      SEL_STATUS: return REG_STATUS;
      default:    return insn[21:17];
    endcase
  endfunction

endpackage

// File: rtl/stage_decode_read_controls.sv
// Opcode -> register-read selects, which ports carry a real source operand,
// and load detection. Purely combinational.
module decode_controls
  import stage_decode_read_pkg::*;
(
  input  logic [4:0] opcode,
  output dec_ctrl_t  ctrl
);

  always_comb begin
    ctrl = '{sel_a: SEL_RS, sel_b: SEL_RT, uses_a: 1'b0, uses_b: 1'b0, is_lw: 1'b0};
    case (opcode)
      OP_R:    begin ctrl.uses_a = 1'b1; ctrl.uses_b = 1'b1; end
      OP_ADDI: ctrl.uses_a = 1'b1;
      OP_LW:   begin ctrl.uses_a = 1'b1; ctrl.is_lw = 1'b1; end
      OP_SW:   begin ctrl.sel_b = SEL_RD; ctrl.uses_a = 1'b1; ctrl.uses_b = 1'b1; end
      OP_BNE, OP_BLT: begin
        ctrl.sel_a  = SEL_RD;
        ctrl.sel_b  = SEL_RS;
        ctrl.uses_a = 1'b1;
        ctrl.uses_b = 1'b1;
      end
      OP_JR:   begin ctrl.sel_a = SEL_RD; ctrl.uses_a = 1'b1; end
      OP_BEX:  begin ctrl.sel_a = SEL_STATUS; ctrl.uses_a = 1'b1; end
      default: ;
    endcase
  end

endmodule

// File: rtl/stage_decode_read.sv
// Decode / register-read stage: regfile read addressing, same-cycle writeback
// bypass, load-use interlock and the D/X pipeline latch.
module stage_decode_read
  import stage_decode_read_pkg::*;
#(
  parameter int          WIDTH    = 32,
  parameter logic [31:0] NOP_INSN = 32'h0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [31:0]      insn_fd,
  input  logic [WIDTH-1:0] pc_plus_4_fd,
  input  logic             flush,
  output logic [4:0]       ctrl_readRegA,
  output logic [4:0]       ctrl_readRegB,
  input  logic [WIDTH-1:0] data_readRegA,
  input  logic [WIDTH-1:0] data_readRegB,
  input  logic             wb_we,
  input  logic [4:0]       ctrl_writeReg,
  input  logic [WIDTH-1:0] data_writeReg,
  input  logic             wb_status_we,
  input  logic [WIDTH-1:0] data_writeStatusReg,
  output logic             stall,
  output logic [31:0]      insn_dx,
  output logic [WIDTH-1:0] pc_plus_4_dx,
  output logic [WIDTH-1:0] opA_dx,
  output logic [WIDTH-1:0] opB_dx,
  output logic [WIDTH-1:0] imm_dx,
  output logic [26:0]      target_dx
);

  dec_ctrl_t        ctrl;
  logic [WIDTH-1:0] op_a, op_b;
  logic [WIDTH-1:0] imm_sext;
  logic             lw_dx;

  decode_controls u_ctrl (
    .opcode (insn_fd[31:27]),
    .ctrl   (ctrl)
  );

  assign ctrl_readRegA = pick_reg(ctrl.sel_a, insn_fd);
  assign ctrl_readRegB = pick_reg(ctrl.sel_b, insn_fd);

  // Status write is checked before the plain write so rstatus wins on r30.
  function automatic logic [WIDTH-1:0] bypass(
    input logic [4:0]       addr,
    input logic [WIDTH-1:0] rf_data,
    input logic             we,
    input logic [4:0]       wr,
    input logic [WIDTH-1:0] wd,
    input logic             swe,
    input logic [WIDTH-1:0] sd
  );
    if (addr == REG_ZERO)                return '0;
    else if (swe && addr == REG_STATUS)  return sd;
    else if (we && wr == addr)           return wd;
    else                                 return rf_data;
  endfunction

  assign op_a = bypass(ctrl_readRegA, data_readRegA, wb_we, ctrl_writeReg, data_writeReg,
                       wb_status_we, data_writeStatusReg);
  assign op_b = bypass(ctrl_readRegB, data_readRegB, wb_we, ctrl_writeReg, data_writeReg,
                       wb_status_we, data_writeStatusReg);

  assign imm_sext = {{(WIDTH-17){insn_fd[16]}}, insn_fd[16:0]};

  // lw_dx already excludes rd==0, so only the address match remains here.
  assign stall = !reset && lw_dx &&
                 ((ctrl.uses_a && ctrl_readRegA == insn_dx[26:22]) ||
                  (ctrl.uses_b && ctrl_readRegB == insn_dx[26:22]));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      insn_dx      <= NOP_INSN;
      pc_plus_4_dx <= '0;
      opA_dx       <= '0;
      opB_dx       <= '0;
      imm_dx       <= '0;
      target_dx    <= '0;
      lw_dx        <= 1'b0;
    end else if (flush || stall) begin
      insn_dx      <= NOP_INSN;
      pc_plus_4_dx <= '0;
      opA_dx       <= '0;
      opB_dx       <= '0;
      imm_dx       <= '0;
      target_dx    <= '0;
      lw_dx        <= 1'b0;
    end else begin
      insn_dx      <= insn_fd;
      pc_plus_4_dx <= pc_plus_4_fd;
      opA_dx       <= op_a;
      opB_dx       <= op_b;
      imm_dx       <= imm_sext;
      target_dx    <= insn_fd[26:0];
      lw_dx        <= ctrl.is_lw && (insn_fd[26:22] != REG_ZERO);
    end
  end

endmodule

// File: tb/tb_stage_decode_read.sv
// Directed bench for stage_decode_read: per-cycle comparison against an
// instruction-level model, plus hand-computed spot checks.
module tb_stage_decode_read;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] insn_fd = '0, pc_plus_4_fd = '0;
  logic        flush = 1'b0;
  logic [4:0]  ctrl_readRegA, ctrl_readRegB;
  logic [31:0] data_readRegA, data_readRegB;
  logic        wb_we = 1'b0;
  logic [4:0]  ctrl_writeReg = '0;
  logic [31:0] data_writeReg = '0;
  logic        wb_status_we = 1'b0;
  logic [31:0] data_writeStatusReg = '0;
  logic        stall;
  logic [31:0] insn_dx, pc_plus_4_dx, opA_dx, opB_dx, imm_dx;
  logic [26:0] target_dx;

  int checks = 0;
  int errors = 0;
  logic [31:0] rf [32];
  logic [31:0] pc = 32'h4;

  always #5 clock = ~clock;

  assign data_readRegA = rf[ctrl_readRegA];
  assign data_readRegB = rf[ctrl_readRegB];

  stage_decode_read #(.WIDTH(32), .NOP_INSN(32'h0)) dut (
    .clock(clock), .reset(reset), .insn_fd(insn_fd), .pc_plus_4_fd(pc_plus_4_fd),
    .flush(flush), .ctrl_readRegA(ctrl_readRegA), .ctrl_readRegB(ctrl_readRegB),
    .data_readRegA(data_readRegA), .data_readRegB(data_readRegB), .wb_we(wb_we),
    .ctrl_writeReg(ctrl_writeReg), .data_writeReg(data_writeReg),
    .wb_status_we(wb_status_we), .data_writeStatusReg(data_writeStatusReg),
    .stall(stall), .insn_dx(insn_dx), .pc_plus_4_dx(pc_plus_4_dx), .opA_dx(opA_dx),
    .opB_dx(opB_dx), .imm_dx(imm_dx), .target_dx(target_dx)
  );

  // ---------------- instruction-level model ----------------
  function automatic logic [31:0] rtype(input int rd, input int rs, input int rt);
    return {5'b00000, rd[4:0], rs[4:0], rt[4:0], 12'd0};
  endfunction
  function automatic logic [31:0] itype(input logic [4:0] op, input int rd, input int rs,
                                        input logic [16:0] imm);
    return {op, rd[4:0], rs[4:0], imm};
  endfunction
  function automatic logic [31:0] jtype(input logic [4:0] op, input logic [26:0] t);
    return {op, t};
  endfunction

  // Is register r one of the sources this instruction really reads?
  function automatic logic reads(input logic [31:0] i, input logic [4:0] r);
    logic [4:0] rd, rs, rt;
    rd = i[26:22]; rs = i[21:17]; rt = i[16:12];
    case (i[31:27])
      5'b00000:           return (r == rs) || (r == rt);
      5'b00101, 5'b01000: return r == rs;
      5'b00111:           return (r == rs) || (r == rd);
      5'b00010, 5'b00110: return (r == rd) || (r == rs);
      5'b00100:           return r == rd;
      5'b10110:           return r == 5'd30;
      default:            return 1'b0;
    endcase
  endfunction

  function automatic logic [4:0] src_a(input logic [31:0] i);
    case (i[31:27])
      5'b00010, 5'b00110, 5'b00100: return i[26:22];
      5'b10110:                     return 5'd30;
      default:                      return i[21:17];
    endcase
  endfunction
  function automatic logic [4:0] src_b(input logic [31:0] i);
    case (i[31:27])
      5'b00010, 5'b00110: return i[21:17];
      5'b00111:           return i[26:22];
      default:            return i[16:12];
    endcase
  endfunction

  // Architectural value of register r as seen this cycle.
  function automatic logic [31:0] val(input logic [4:0] r);
    if (r == 0) return 32'h0;
    if (wb_status_we && r == 5'd30) return data_writeStatusReg;
    if (wb_we && ctrl_writeReg == r) return data_writeReg;
    return rf[r];
  endfunction

  logic [31:0] e_insn, e_pc, e_a, e_b, e_imm;
  logic [26:0] e_tgt;

  function automatic logic exp_stall();
    return !reset && e_insn[31:27] == 5'b01000 && e_insn[26:22] != 0 &&
           reads(insn_fd, e_insn[26:22]);
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset || flush || exp_stall()) begin
      e_insn <= 32'h0; e_pc <= '0; e_a <= '0; e_b <= '0; e_imm <= '0; e_tgt <= '0;
    end else begin
      e_insn <= insn_fd;
      e_pc   <= pc_plus_4_fd;
      e_a    <= val(src_a(insn_fd));
      e_b    <= val(src_b(insn_fd));
      e_imm  <= {{15{insn_fd[16]}}, insn_fd[16:0]};
      e_tgt  <= insn_fd[26:0];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      chk("stall", {31'd0, stall}, {31'd0, exp_stall()});
      chk("insn_dx", insn_dx, e_insn);
      chk("pc_plus_4_dx", pc_plus_4_dx, e_pc);
      chk("opA_dx", opA_dx, e_a);
      chk("opB_dx", opB_dx, e_b);
      chk("imm_dx", imm_dx, e_imm);
      chk("target_dx", {5'd0, target_dx}, {5'd0, e_tgt});
    end
  end

  // ---------------- stimulus ----------------
  task automatic set(input logic [31:0] i, input logic fl = 1'b0,
                     input logic we = 1'b0, input int wr = 0, input logic [31:0] wd = '0,
                     input logic swe = 1'b0, input logic [31:0] sd = '0);
    insn_fd = i; pc_plus_4_fd = pc; flush = fl;
    wb_we = we; ctrl_writeReg = wr[4:0]; data_writeReg = wd;
    wb_status_we = swe; data_writeStatusReg = sd;
    pc = pc + 4;
  endtask

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  localparam logic [31:0] ADD_3_1_2 = 32'h00C2_2000;

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'h1000 + i;
    rf[1] = 32'd5;
    rf[2] = 32'd7;
    #1 reset = 1'b1;
    @(negedge clock);
    chk("reset insn_dx", insn_dx, 32'h0);
    chk("reset opA_dx", opA_dx, 32'h0);
    chk("reset stall", {31'd0, stall}, 32'h0);
    @(posedge clock); #2 reset = 1'b0;

    // plain add, then writeback bypass, then write to r0
    chk("add encoding", rtype(3, 1, 2), ADD_3_1_2);
    set(rtype(3, 1, 2)); #1 chk("add stall", {31'd0, stall}, 32'h0); tick();
    chk("add opA", opA_dx, 32'd5);
    chk("add opB", opB_dx, 32'd7);
    set(rtype(3, 1, 2), 0, 1, 2, 32'd99); tick();
    chk("bypass opB", opB_dx, 32'd99);
    set(rtype(3, 1, 0), 0, 1, 0, 32'd99); tick();
    chk("r0 opB", opB_dx, 32'd0);

    // load-use: one bubble, then the held add issues
    set(itype(5'b01000, 4, 1, 17'd8)); tick();
    set(rtype(5, 4, 1)); #1 chk("lu stall", {31'd0, stall}, 32'h1); tick();
    chk("lu bubble", insn_dx, 32'h0);
    #1 chk("lu stall clear", {31'd0, stall}, 32'h0); tick();
    chk("lu issue", insn_dx, rtype(5, 4, 1));

    // lw followed by j: no interlock
    set(itype(5'b01000, 4, 1, 17'd8)); tick();
    set(jtype(5'b00001, 27'd100)); #1 chk("lw-j stall", {31'd0, stall}, 32'h0); tick();
    chk("j issue", insn_dx, 32'h0800_0064);

    // bex and rstatus priority
    set(jtype(5'b10110, 27'd40), 0, 0, 0, 0, 1, 32'd1); tick();
    chk("bex opA", opA_dx, 32'd1);
    set(jtype(5'b10110, 27'd40), 0, 1, 30, 32'd55, 1, 32'd77); tick();
    chk("status wins", opA_dx, 32'd77);
    set(jtype(5'b10101, 27'd9), 0, 1, 30, 32'd55, 1, 32'd77); tick();

    // stall and flush together, then sign-extended addi decodes
    set(itype(5'b01000, 4, 1, 17'd8)); tick();
    set(rtype(5, 4, 1), 1); #1 chk("fl stall", {31'd0, stall}, 32'h1); tick();
    chk("fl nop", insn_dx, 32'h0);
    set(itype(5'b00101, 7, 1, 17'h1FFFF)); tick();
    chk("addi issue", insn_dx, 32'h29C3_FFFF);
    chk("imm sext", imm_dx, 32'hFFFF_FFFF);

    // lw to r0 never interlocks
    set(itype(5'b01000, 0, 1, 17'd8)); tick();
    set(rtype(5, 0, 1)); #1 chk("lw r0 stall", {31'd0, stall}, 32'h0); tick();

    // sw reads rd
    set(itype(5'b01000, 6, 1, 17'd8)); tick();
    set(itype(5'b00111, 6, 1, 17'd0)); #1 chk("sw stall", {31'd0, stall}, 32'h1); tick();
    tick();

    // addi does not read the rt field even when it matches
    set(itype(5'b01000, 4, 1, 17'd8)); tick();
    set(itype(5'b00101, 7, 1, 17'h04000)); #1 chk("addi rt", {31'd0, stall}, 32'h0); tick();

    // jr and blt read rd
    set(itype(5'b01000, 4, 1, 17'd8)); tick();
    set(itype(5'b00100, 4, 0, 17'd0)); #1 chk("jr stall", {31'd0, stall}, 32'h1); tick();
    tick();
    set(itype(5'b01000, 4, 1, 17'd8)); tick();
    set(itype(5'b00110, 4, 2, 17'd3)); #1 chk("blt stall", {31'd0, stall}, 32'h1); tick();
    tick();

    // async reset mid-stall
    set(itype(5'b01000, 4, 1, 17'd8)); tick();
    set(rtype(5, 4, 1)); #1 chk("pre-rst stall", {31'd0, stall}, 32'h1);
    reset = 1'b1;
    #1;
    chk("rst stall", {31'd0, stall}, 32'h0);
    chk("rst insn_dx", insn_dx, 32'h0);
    chk("rst opA_dx", opA_dx, 32'h0);
    chk("rst pc_dx", pc_plus_4_dx, 32'h0);
    @(negedge clock); #1 reset = 1'b0;
    tick();
    chk("post-rst issue", insn_dx, rtype(5, 4, 1));

    set(32'h0); tick();
    tick();
    @(negedge clock); #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
